tristate_bus_arbiter: RTL and testbench
=======================================

Name: tristate_bus_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one tristate output pad (O_BUFT I/OE pair) among NUM_REQ internal requesters.
- Grants the pad to one owner at a time and registers that owner's data onto the pad data input.
- Guarantees a programmable turnaround gap, with OE low, between owners so two drivers never overlap.
- Sits between user logic and the O_BUFT instance: BUS_O drives the buffer's I pin, BUS_OE drives its OE pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 1, data bits per requester and on the pad bus
TURN_CYCLES, 1, extra OE-low idle cycles inserted after an owner releases (0..15)
MAX_HOLD, 16, maximum DRIVE cycles while another request is pending; 0 = unlimited

Ports:
CLK  input  1  single clock, rising edge
RST  input  1  asynchronous, active-high reset
REQ  input  NUM_REQ  per-requester request, level, held high while access is wanted
DATA  input  NUM_REQ*DATA_WIDTH  requester data, slice i = DATA[i*DATA_WIDTH +: DATA_WIDTH]
GNT  output  NUM_REQ  one-hot grant, registered
BUS_O  output  DATA_WIDTH  registered data to the O_BUFT I pin
BUS_OE  output  1  registered output enable to the O_BUFT OE pin
BUSY  output  1  registered, high when state != IDLE

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-DRIVE:
  - GNT=0, BUS_O=0, BUS_OE=0, BUSY=0.
  - state=IDLE, rr pointer=0, hold and turn counters=0.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - If any REQ is high, pick the first set bit searching upward from the pointer, with wrap.
  - At the next edge: GNT[k]=1, BUS_OE=1, BUS_O=DATA slice k, state=DRIVE, hold=1.
  - Latency from REQ high in IDLE to GNT/OE high is 1 cycle.
- DRIVE:
  - Every edge, BUS_O <= DATA slice k, so pad data lags DATA by 1 cycle.
  - GNT and OE stay high.
  - hold increments and saturates at MAX_HOLD.
- DRIVE exit conditions, evaluated each cycle:
  - (a) REQ[k] sampled low, or
  - (b) MAX_HOLD!=0, hold==MAX_HOLD and any other REQ is high.
- On exit, at the next edge:
  - GNT=0, BUS_OE=0, BUS_O=0.
  - pointer = (k+1) mod NUM_REQ.
  - state = TURN if TURN_CYCLES>0, else IDLE.
- TURN:
  - Counts TURN_CYCLES cycles with OE low, then goes to IDLE.
  - REQ changes during TURN are ignored until IDLE.
- Gap rule: between two owners, BUS_OE is low for exactly TURN_CYCLES+1 cycles (TURN cycles plus one IDLE arbitration cycle).
  - This holds even when the same requester re-wins.
- Forced release (b):
  - The owner loses GNT while its REQ is still high.
  - It must keep REQ high to re-arbitrate and now has the lowest priority.
- No other requester pending: the owner keeps the bus indefinitely; the saturated hold counter is harmless.
- REQ[k] dropping and another REQ rising in the same cycle: exit (a) takes effect; the new requester is considered only in IDLE.
- Invariants:
  - GNT is one-hot or zero.
  - BUS_OE == |GNT always.
  - BUS_O==0 whenever BUS_OE==0.
- Counter widths:
  - hold: $clog2(MAX_HOLD+1), minimum 1 bit.
  - turn: 4 bits.
- Elaboration error if NUM_REQ<2, NUM_REQ>8, or TURN_CYCLES>15.

Test Plan:
1. Reset then idle (defaults): RST high 3 cycles, REQ=0 -> GNT=0, BUS_OE=0, BUS_O=0, BUSY=0 on every cycle.
2. Single requester:
   - REQ[2] high at cycle 0, DATA slice 2 toggling 1,0,1,... -> GNT=4'b0100 and BUS_OE=1 from cycle 1, BUS_O equals the previous-cycle DATA.
   - REQ[2] low at cycle 10 -> GNT=0, OE=0 at cycle 11, BUSY=1 for 1 cycle of TURN, then IDLE.
3. Round-robin rotation:
   - REQ=4'b1111 held, MAX_HOLD=4, TURN_CYCLES=1 -> grant order 0,1,2,3,0.
   - Each owner holds 4 cycles, OE low 2 cycles between owners.
4. Forced release:
   - REQ[0] held, REQ[3] raised at DRIVE cycle 2, MAX_HOLD=16 -> GNT[0] drops after hold reaches 16.
   - Then 2 OE-low cycles, then GNT[3]; requester 0 is regranted only after 3 releases.
5. Mid-drive reset and turnaround variants:
   - Assert RST asynchronously mid-DRIVE between edges -> GNT and BUS_OE go to 0 before the next edge; the pointer restarts at 0, so REQ=4'b1010 yields GNT[1] first.
   - TURN_CYCLES=0 -> OE-low gap is exactly 1 cycle.
   - TURN_CYCLES=15 -> OE-low gap is 16 cycles.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared O_BUFT pad.
// Registers data/OE and enforces an OE-low turnaround gap between owners.
module tristate_bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 1,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] DATA,
  output logic [NUM_REQ-1:0]            GNT,
  output logic [DATA_WIDTH-1:0]         BUS_O,
  output logic                          BUS_OE,
  output logic                          BUSY
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 ||
      TURN_CYCLES < 0 || TURN_CYCLES > 15) begin : g_bad_cfg
    $error("tristate_bus_arbiter: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         own_q, own_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [3:0]            turn_q, turn_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [DATA_WIDTH-1:0] bus_o_q, bus_o_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;

  logic          found;
  logic [PW-1:0] pick;
  int            idx;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  logic other_req;
  logic max_hit;
  logic [PW-1:0] ptr_nxt;

  assign other_req = |(REQ & ~gnt_q);
  assign max_hit   = (MAX_HOLD != 0) &&
                     (hold_q == HW'(MAX_HOLD)) && other_req;
  assign ptr_nxt   = (own_q == PW'(NUM_REQ - 1)) ?
                     '0 : own_q + PW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    bus_o_d = bus_o_q;
    oe_d    = oe_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = DRIVE;
          own_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          oe_d        = 1'b1;
          bus_o_d     = DATA[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          hold_d      = HW'(1);
        end
      end
      DRIVE: begin
        bus_o_d = DATA[int'(own_q)*DATA_WIDTH +: DATA_WIDTH];
        if (!REQ[own_q] || max_hit) begin
          gnt_d   = '0;
          oe_d    = 1'b0;
          bus_o_d = '0;
          ptr_d   = ptr_nxt;
          hold_d  = '0;
          turn_d  = '0;
          state_d = (TURN_CYCLES > 0) ? TURN : IDLE;
        end else if (MAX_HOLD != 0 && hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_q == 4'(TURN_CYCLES - 1)) begin
          state_d = IDLE;
          turn_d  = '0;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      bus_o_q <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      bus_o_q <= bus_o_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT    = gnt_q;
  assign BUS_O  = bus_o_q;
  assign BUS_OE = oe_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter.
// Four instances cover default, short-hold and turnaround variants.
module tb_tristate_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] DATA;

  logic [3:0] gnt    [4];
  logic       bus_o  [4];
  logic       bus_oe [4];
  logic       busy   [4];

  int checks = 0;
  int errors = 0;

  logic [3:0] eg;
  logic       eo;
  logic       eb;
  logic       prev;
  int         gap;

  always #5 CLK = ~CLK;

  tristate_bus_arbiter u0 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
    .GNT(gnt[0]), .BUS_O(bus_o[0]), .BUS_OE(bus_oe[0]), .BUSY(busy[0])
  );

  tristate_bus_arbiter #(.MAX_HOLD(4)) u1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
    .GNT(gnt[1]), .BUS_O(bus_o[1]), .BUS_OE(bus_oe[1]), .BUSY(busy[1])
  );

  tristate_bus_arbiter #(.TURN_CYCLES(0)) u2 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
    .GNT(gnt[2]), .BUS_O(bus_o[2]), .BUS_OE(bus_oe[2]), .BUSY(busy[2])
  );

  tristate_bus_arbiter #(.TURN_CYCLES(15)) u3 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DATA(DATA),
    .GNT(gnt[3]), .BUS_O(bus_o[3]), .BUS_OE(bus_oe[3]), .BUSY(busy[3])
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    REQ  = '0;
    DATA = '0;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST  = 1'b1;
    REQ  = '0;
    DATA = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) RST = 1'b0;
      tick();
      for (int u = 0; u < 4; u++) begin
        checks++;
        if ({gnt[u], bus_o[u], bus_oe[u], busy[u]} !== 7'b0) begin
          errors++;
          $display("FAIL reset u%0d c=%0d got gnt=%b o=%b oe=%b busy=%b exp all 0",
                   u, c, gnt[u], bus_o[u], bus_oe[u], busy[u]);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    REQ     = 4'b0100;
    DATA[2] = 1'b1;
    prev    = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if ({gnt[0], bus_oe[0], busy[0], bus_o[0]} !== {4'b0100, 1'b1, 1'b1, prev}) begin
        errors++;
        $display("FAIL single c=%0d got gnt=%b oe=%b busy=%b o=%b exp 0100 1 1 %b",
                 c, gnt[0], bus_oe[0], busy[0], bus_o[0], prev);
      end
      prev    = (c % 2 == 0);
      DATA[2] = prev;
      if (c == 10) REQ = '0;
    end
    tick();
    checks++;
    if ({gnt[0], bus_oe[0], bus_o[0], busy[0]} !== 7'b0000_001) begin
      errors++;
      $display("FAIL single_release got gnt=%b oe=%b o=%b busy=%b exp 0000 0 0 1",
               gnt[0], bus_oe[0], bus_o[0], busy[0]);
    end
    tick();
    checks++;
    if ({gnt[0], bus_oe[0], busy[0]} !== 6'b0) begin
      errors++;
      $display("FAIL single_idle got gnt=%b oe=%b busy=%b exp 0000 0 0",
               gnt[0], bus_oe[0], busy[0]);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    DATA = 4'b0101;
    REQ  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      eo = DATA[k % 4];
      for (int h = 0; h < 4; h++) begin
        tick();
        checks++;
        if ({gnt[1], bus_oe[1], bus_o[1], busy[1]} !== {eg, 1'b1, eo, 1'b1}) begin
          errors++;
          $display("FAIL rotation k=%0d h=%0d got gnt=%b oe=%b o=%b busy=%b exp %b 1 %b 1",
                   k, h, gnt[1], bus_oe[1], bus_o[1], busy[1], eg, eo);
        end
      end
      if (k < 4) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          eb = (g == 0);
          checks++;
          if ({gnt[1], bus_oe[1], bus_o[1], busy[1]} !== {6'b0, eb}) begin
            errors++;
            $display("FAIL rotation_gap k=%0d g=%0d got gnt=%b oe=%b o=%b busy=%b exp 0000 0 0 %b",
                     k, g, gnt[1], bus_oe[1], bus_o[1], busy[1], eb);
          end
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    DATA = 4'b0100;
    REQ  = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if ({gnt[1], bus_oe[1], bus_o[1]} !== {4'b0100, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL no_preempt c=%0d got gnt=%b oe=%b o=%b exp 0100 1 1",
                 c, gnt[1], bus_oe[1], bus_o[1]);
      end
    end
  endtask

  task automatic test_forced();
    do_reset();
    DATA = 4'b0001;
    REQ  = 4'b0001;
    for (int c = 1; c <= 37; c++) begin
      tick();
      if (c <= 16) eg = 4'b0001;
      else if (c >= 19 && c <= 34) eg = 4'b1000;
      else if (c == 37) eg = 4'b0001;
      else eg = 4'b0000;
      eo = eg[0];
      eb = (eg != 0) || c == 17 || c == 35;
      checks++;
      if ({gnt[0], bus_oe[0], bus_o[0], busy[0]} !== {eg, |eg, eo, eb}) begin
        errors++;
        $display("FAIL forced c=%0d got gnt=%b oe=%b o=%b busy=%b exp %b %b %b %b",
                 c, gnt[0], bus_oe[0], bus_o[0], busy[0], eg, |eg, eo, eb);
      end
      if (c == 2) REQ = 4'b1001;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    DATA = 4'b0010;
    REQ  = 4'b0100;
    tick();
    REQ = '0;
    tick();
    tick();
    REQ = 4'b1000;
    tick();
    checks++;
    if (gnt[0] !== 4'b1000) begin
      errors++;
      $display("FAIL async_setup got gnt=%b exp 1000", gnt[0]);
    end
    tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({gnt[0], bus_oe[0], busy[0]} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b oe=%b busy=%b exp 0000 0 0",
               gnt[0], bus_oe[0], busy[0]);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    REQ = 4'b1010;
    tick();
    checks++;
    if ({gnt[0], bus_oe[0], bus_o[0]} !== {4'b0010, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL async_ptr got gnt=%b oe=%b o=%b exp 0010 1 1",
               gnt[0], bus_oe[0], bus_o[0]);
    end
  endtask

  task automatic test_turn_variants();
    for (int s = 2; s < 4; s++) begin
      gap = (s == 2) ? 1 : 16;
      do_reset();
      REQ = 4'b0011;
      for (int c = 1; c <= 17 + gap; c++) begin
        tick();
        if (c <= 16) eg = 4'b0001;
        else if (c == 17 + gap) eg = 4'b0010;
        else eg = 4'b0000;
        eb = (eg != 0) || (c > 16 && c < 16 + gap);
        checks++;
        if ({gnt[s], bus_oe[s], busy[s]} !== {eg, |eg, eb}) begin
          errors++;
          $display("FAIL turn u%0d c=%0d got gnt=%b oe=%b busy=%b exp %b %b %b",
                   s, c, gnt[s], bus_oe[s], busy[s], eg, |eg, eb);
        end
      end
    end
  endtask

  initial begin
    RST  = 1'b1;
    REQ  = '0;
    DATA = '0;
    test_reset();
    test_single();
    test_rotation();
    test_no_preempt();
    test_forced();
    test_async_reset();
    test_turn_variants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
